// File: rtl/exc_seq_pkg.sv
// Shared encodings for the exception sequencer and the memory-address mux:
// selector codes, cause codes, sequencer state encoding and small helpers.
package exc_seq_pkg;

    // Memory-address selector codes (also consumed by the address mux)
    localparam logic [2:0] SEL_PC     = 3'd0;
    localparam logic [2:0] SEL_ALUOUT = 3'd1;
    localparam logic [2:0] SEL_A      = 3'd2;
    localparam logic [2:0] SEL_B      = 3'd3;
    localparam logic [2:0] SEL_V253   = 3'd4;
    localparam logic [2:0] SEL_V254   = 3'd5;
    localparam logic [2:0] SEL_V255   = 3'd6;

    // Latched exception cause codes
    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_OPCODE = 2'd1;
    localparam logic [1:0] CAUSE_OVF    = 2'd2;
    localparam logic [1:0] CAUSE_DIV0   = 2'd3;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SAVE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_LOAD = 2'd3;

    // Resolve simultaneous events: opcode beats overflow beats div0
    function automatic logic [1:0] pick_cause(input logic op, input logic ovf, input logic div0);
        logic [1:0] cause;
        cause = CAUSE_NONE;
        if (op)        cause = CAUSE_OPCODE;
        else if (ovf)  cause = CAUSE_OVF;
        else if (div0) cause = CAUSE_DIV0;
        return cause;
    endfunction

    // Vector slot selector belonging to a cause
    function automatic logic [2:0] cause_to_sel(input logic [1:0] cause);
        logic [2:0] sel;
        case (cause)
            CAUSE_OPCODE: sel = SEL_V253;
            CAUSE_OVF:    sel = SEL_V254;
            default:      sel = SEL_V255;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exc_seq.sv
// Exception sequencer: on an exception event it saves EPC, steers the
// memory-address mux to the vector slot for MEM_WAIT cycles, then loads the
// zero-extended handler byte into PC. Passes the control selector through
// while idle and raises busy to stall main control while sequencing.
module exc_seq
    import exc_seq_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [2:0]  ctrl_mem_sel,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  mem_sel,
    output logic        epc_wr,
    output logic [31:0] epc_value,
    output logic        pc_wr,
    output logic [31:0] pc_value,
    output logic [1:0]  exc_cause,
    output logic        busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic [1:0] cause_reg;
    logic [1:0] cause_next;
    logic       exc_any;

    // Only the handler byte of the read data is used
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[31:8];

    assign exc_any = exc_opcode | exc_overflow | exc_div0;

    // Next-state, wait counter and cause latch; events only taken in IDLE
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cause_next = cause_reg;
        case (state_reg)
            ST_IDLE: begin
                if (exc_any) begin
                    cause_next = pick_cause(exc_opcode, exc_overflow, exc_div0);
                    state_next = ST_SAVE;
                end
            end
            ST_SAVE: begin
                cnt_next   = WAIT_LOAD;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) state_next = ST_LOAD;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous abort on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            cause_reg <= CAUSE_NONE;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cause_reg <= cause_next;
        end
    end

    // Output decode: pass-through while idle, vector slot while busy
    always_comb begin
        mem_sel   = ctrl_mem_sel;
        epc_wr    = 1'b0;
        epc_value = 32'd0;
        pc_wr     = 1'b0;
        pc_value  = 32'd0;
        busy      = 1'b0;
        case (state_reg)
            ST_SAVE: begin
                busy      = 1'b1;
                mem_sel   = cause_to_sel(cause_reg);
                epc_wr    = 1'b1;
                epc_value = pc_in - 32'd4;
            end
            ST_WAIT: begin
                busy    = 1'b1;
                mem_sel = cause_to_sel(cause_reg);
            end
            ST_LOAD: begin
                busy     = 1'b1;
                mem_sel  = cause_to_sel(cause_reg);
                pc_wr    = 1'b1;
                pc_value = {24'd0, mem_rdata[7:0]};
            end
            default: begin
                mem_sel = ctrl_mem_sel;
            end
        endcase
    end

    assign exc_cause = cause_reg;

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: a cycle-position model of the exception sequence is
// compared against the DUT on every falling edge, with directed scenarios
// carrying hand-computed expectations and a randomized soak afterwards.
module tb_exc_seq;

    localparam int MEM_WAIT = 2;
    localparam int SEQ_LEN  = MEM_WAIT + 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exc_opcode = 1'b0;
    logic        exc_overflow = 1'b0;
    logic        exc_div0 = 1'b0;
    logic [2:0]  ctrl_mem_sel = 3'd0;
    logic [31:0] pc_in = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic [2:0]  mem_sel;
    logic        epc_wr;
    logic [31:0] epc_value;
    logic        pc_wr;
    logic [31:0] pc_value;
    logic [1:0]  exc_cause;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    exc_seq #(.MEM_WAIT(MEM_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
        .ctrl_mem_sel(ctrl_mem_sel), .pc_in(pc_in), .mem_rdata(mem_rdata),
        .mem_sel(mem_sel), .epc_wr(epc_wr), .epc_value(epc_value),
        .pc_wr(pc_wr), .pc_value(pc_value), .exc_cause(exc_cause), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Model: position within the exception sequence (0 = idle, 1 = save,
    // SEQ_LEN = load) and the last accepted cause.
    int         m_pos = 0;
    logic [1:0] m_cause = 2'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos   <= 0;
            m_cause <= 2'd0;
        end else if (m_pos == 0) begin
            if (exc_opcode || exc_overflow || exc_div0) begin
                m_cause <= exc_opcode ? 2'd1 : (exc_overflow ? 2'd2 : 2'd3);
                m_pos   <= 1;
            end
        end else if (m_pos == SEQ_LEN) begin
            m_pos <= 0;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [2:0]  e_sel;
        logic        e_epc_wr, e_pc_wr;
        logic [31:0] e_epc, e_pc;
        e_sel    = (m_pos == 0) ? ctrl_mem_sel : 3'(int'(m_cause) + 3);
        e_epc_wr = (m_pos == 1);
        e_pc_wr  = (m_pos == SEQ_LEN);
        e_epc    = e_epc_wr ? pc_in - 32'd4 : 32'd0;
        e_pc     = e_pc_wr ? {24'd0, mem_rdata[7:0]} : 32'd0;
        chk("mdl_busy", 32'(busy), 32'(m_pos != 0));
        chk("mdl_mem_sel", 32'(mem_sel), 32'(e_sel));
        chk("mdl_epc_wr", 32'(epc_wr), 32'(e_epc_wr));
        chk("mdl_epc_value", epc_value, e_epc);
        chk("mdl_pc_wr", 32'(pc_wr), 32'(e_pc_wr));
        chk("mdl_pc_value", pc_value, e_pc);
        chk("mdl_exc_cause", 32'(exc_cause), 32'(m_cause));
    end

    // Raise the given events for exactly one sampling edge
    task automatic fire(input logic op, input logic ovf, input logic d0);
        @(posedge clk); #1;
        exc_opcode = op; exc_overflow = ovf; exc_div0 = d0;
        @(posedge clk); #1;
        exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
    endtask

    task automatic settle();
        repeat (SEQ_LEN + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int cnt2;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        ctrl_mem_sel = 3'd3;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cause", 32'(exc_cause), 32'd0);
        chk("rst_mem_sel", 32'(mem_sel), 32'd3);
        @(posedge clk); #1;
        reset_n = 1'b1;
        settle();
        $display("txn reset: busy=%0d cause=%0d", busy, exc_cause);

        // Overflow, pc_in=0x40, handler byte 0x7C
        pc_in = 32'h40; mem_rdata = 32'h1234567C; ctrl_mem_sel = 3'd0;
        fire(1'b0, 1'b1, 1'b0);
        cnt = 0;
        @(negedge clk);
        cnt += int'(busy);
        chk("ovf_epc_wr", 32'(epc_wr), 32'd1);
        chk("ovf_epc_value", epc_value, 32'h3C);
        chk("ovf_mem_sel_save", 32'(mem_sel), 32'd5);
        repeat (MEM_WAIT) begin
            @(negedge clk);
            cnt += int'(busy);
            chk("ovf_mem_sel_wait", 32'(mem_sel), 32'd5);
            chk("ovf_pc_wr_wait", 32'(pc_wr), 32'd0);
        end
        @(negedge clk);
        cnt += int'(busy);
        chk("ovf_pc_wr", 32'(pc_wr), 32'd1);
        chk("ovf_pc_value", pc_value, 32'h7C);
        chk("ovf_mem_sel_load", 32'(mem_sel), 32'd5);
        @(negedge clk);
        cnt += int'(busy);
        chk("ovf_busy_cycles", 32'(cnt), 32'd4);
        chk("ovf_cause", 32'(exc_cause), 32'd2);
        $display("txn overflow: busy_cycles=%0d cause=%0d", cnt, exc_cause);
        settle();

        // Opcode and div0 together: opcode wins
        fire(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("prio_cause", 32'(exc_cause), 32'd1);
        chk("prio_mem_sel", 32'(mem_sel), 32'd4);
        $display("txn priority: cause=%0d mem_sel=%0d", exc_cause, mem_sel);
        settle();

        // div0 with pc_in=0 wraps EPC
        pc_in = 32'd0; mem_rdata = 32'hAABBCC11;
        fire(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("div0_epc_value", epc_value, 32'hFFFFFFFC);
        chk("div0_mem_sel", 32'(mem_sel), 32'd6);
        repeat (MEM_WAIT + 1) @(negedge clk);
        chk("div0_pc_value", pc_value, 32'h00000011);
        $display("txn div0: pc_value=0x%08h", pc_value);
        settle();

        // Overflow raised during WAIT is ignored
        pc_in = 32'h100;
        fire(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        exc_overflow = 1'b1;
        cnt = 0;
        cnt2 = 0;
        @(negedge clk);
        cnt += int'(pc_wr);
        cnt2 += int'(busy);
        @(posedge clk); #1;
        exc_overflow = 1'b0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(pc_wr);
            cnt2 += int'(busy);
        end
        chk("ign_pc_wr_count", 32'(cnt), 32'd1);
        chk("ign_busy_remaining", 32'(cnt2), 32'(MEM_WAIT + 1));
        chk("ign_cause", 32'(exc_cause), 32'd1);
        $display("txn ignore: pc_wr_count=%0d cause=%0d", cnt, exc_cause);
        settle();

        // Reset during WAIT aborts immediately
        fire(1'b0, 1'b1, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        ctrl_mem_sel = 3'd2;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_sel", 32'(mem_sel), 32'd2);
        chk("abort_cause", 32'(exc_cause), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(pc_wr) + int'(epc_wr);
        end
        chk("abort_no_write", 32'(cnt), 32'd0);
        $display("txn abort: writes_after_release=%0d", cnt);

        // Idle pass-through sweep
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            ctrl_mem_sel = 3'(i);
            @(negedge clk);
            chk("sweep_mem_sel", 32'(mem_sel), 32'(i));
            chk("sweep_writes", 32'(epc_wr | pc_wr), 32'd0);
            $display("txn sweep: ctrl=%0d mem_sel=%0d", i, mem_sel);
        end

        // Randomized soak against the model
        for (int t = 0; t < 600; t++) begin
            @(posedge clk); #1;
            exc_opcode   = ($urandom_range(0, 9) == 0);
            exc_overflow = ($urandom_range(0, 9) == 0);
            exc_div0     = ($urandom_range(0, 9) == 0);
            ctrl_mem_sel = 3'($urandom_range(0, 7));
            pc_in        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            mem_rdata    = $urandom;
            if ($urandom_range(0, 150) == 0) begin
                #1 reset_n = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
            end
            if ((t % 50) == 0)
                $display("txn random %0d: busy=%0d cause=%0d mem_sel=%0d", t, busy, exc_cause, mem_sel);
        end
        exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exc_seq.md
# exc_seq

Exception sequencer for the multicycle datapath: on an invalid-opcode, overflow or divide-by-zero event it takes ownership of the memory-address selector, saves EPC, and fetches the one-byte handler address from the vector slot (253/254/255). It then loads that byte, zero-extended, into PC. It sits between the main control unit and the memory-address mux. While idle it passes the control unit's selector through; while busy it stalls the control unit.

## Interface
Parameters:
- MEM_WAIT, 2, cycles the vector address is held before read data is sampled (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- exc_opcode  in  1  invalid-opcode event, sampled in IDLE only
- exc_overflow  in  1  ALU overflow event, sampled in IDLE only
- exc_div0  in  1  divide-by-zero event, sampled in IDLE only
- ctrl_mem_sel  in  3  selector requested by main control
- pc_in  in  32  current PC (already incremented)
- mem_rdata  in  32  memory read data
- mem_sel  out  3  selector driven to the memory-address mux
- epc_wr  out  1  EPC write enable
- epc_value  out  32  value for EPC
- pc_wr  out  1  PC write enable (exception path)
- pc_value  out  32  handler address for PC
- exc_cause  out  2  latched cause: 0 none, 1 opcode, 2 overflow, 3 div0
- busy  out  1  sequence in progress; main control must stall

## Operation
- States: IDLE, SAVE, WAIT, LOAD.
- IDLE:
  - mem_sel = ctrl_mem_sel (combinational pass-through).
  - epc_wr = pc_wr = busy = 0.
  - If any exception input is high at a rising edge, latch the cause and go to SAVE.
- Priority on simultaneous events: opcode > overflow > div0. Only the winner is latched.
- Vector select: opcode → 3'b100 (253), overflow → 3'b101 (254), div0 → 3'b110 (255).
- SAVE (1 cycle):
  - epc_wr = 1; epc_value = pc_in − 4, modulo 2^32 (pc_in = 0 → 0xFFFFFFFC).
  - mem_sel = vector; wait counter loads MEM_WAIT−1.
  - Go to WAIT.
- WAIT (MEM_WAIT cycles):
  - mem_sel = vector; the counter decrements each cycle.
  - At count 0, go to LOAD.
- LOAD (1 cycle):
  - mem_sel = vector; pc_wr = 1; pc_value = {24'b0, mem_rdata[7:0]}.
  - Go to IDLE.
- busy = 1 in SAVE, WAIT and LOAD.
- Exception inputs are ignored while busy. New events are neither queued nor allowed to overwrite the latched cause.
- exc_cause holds the last serviced cause until the next exception is latched. It is never cleared except by reset.
- epc_value and pc_value are 0 whenever their write enable is low.
- The block never drives selector codes 3'b111, 3'b000–3'b011 on its own; those values appear on mem_sel only via IDLE pass-through.
- An undefined ctrl_mem_sel (3'b111) passes through unchanged in IDLE.

## Timing
- Event sampled at edge n → SAVE during cycle n+1.
- WAIT occupies cycles n+2 .. n+1+MEM_WAIT.
- LOAD occupies cycle n+2+MEM_WAIT; the PC update is visible at the following edge.
- Total busy time is MEM_WAIT+2 cycles; the block returns to IDLE at cycle n+3+MEM_WAIT.
- An exception input high on the same edge that LOAD exits to IDLE is not sampled. It must still be high in the first IDLE cycle to be taken.
- All state, counter and cause registers are reset asynchronously while reset_n = 0.
- Reset values:
  - state = IDLE, exc_cause = 0, counter = 0.
  - epc_wr = pc_wr = busy = 0; epc_value = pc_value = 0.
  - mem_sel = ctrl_mem_sel.
- Reset asserted mid-sequence aborts immediately. No pc_wr or epc_wr is issued after reset deasserts.

## Structure
- Shared package holds:
  - the selector encodings SEL_PC=0, SEL_ALUOUT=1, SEL_A=2, SEL_B=3, SEL_V253=4, SEL_V254=5, SEL_V255=6;
  - the cause codes CAUSE_NONE/OPCODE/OVF/DIV0;
  - the state encoding.
- The existing memory-address mux consumes the same SEL_* constants.
- Single module; no sub-module. The wait counter is 4 bits, inline.

## Test plan
- Overflow with pc_in=0x40, MEM_WAIT=2, mem_rdata[7:0]=0x7C during LOAD → epc_wr with 0x3C one cycle after the event; mem_sel=5 for 4 cycles; pc_wr with 0x0000007C on the 4th; busy high exactly 4 cycles.
- exc_opcode and exc_div0 high on the same edge → exc_cause=1, mem_sel=4; div0 is dropped.
- exc_div0 with pc_in=0 → epc_value=0xFFFFFFFC; mem_sel=6; mem_rdata=0xAABBCC11 yields pc_value=0x00000011.
- exc_overflow pulsed during WAIT → ignored; exc_cause unchanged; exactly one pc_wr; the block returns to IDLE on schedule.
- reset_n low during WAIT → immediately busy=0, state IDLE; mem_sel tracks ctrl_mem_sel=2; no pc_wr after release.
- IDLE with ctrl_mem_sel sweeping 0..7 → mem_sel matches each value in the same cycle; epc_wr=pc_wr=0 throughout.
